// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, period/width helpers, colour-bar masks and the pipeline record.
package vga_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   // Per-pixel flags carried from the request stage to the output register.
   typedef struct packed {
      logic       vis;
      logic       hs;
      logic       vs;
      logic       tp;
      logic [2:0] bar;
   } pipe_t;

   function automatic int unsigned period(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int unsigned coord_w(input int unsigned total);
      return $clog2(total);
   endfunction

   // {R,G,B} on/off per bar, left to right.
   function automatic logic [2:0] bar_mask(input logic [2:0] idx);
      logic [2:0] mask;
      unique case (idx)
         3'd0:    mask = 3'b111;
         3'd1:    mask = 3'b110;
         3'd2:    mask = 3'b011;
         3'd3:    mask = 3'b010;
         3'd4:    mask = 3'b101;
         3'd5:    mask = 3'b100;
         3'd6:    mask = 3'b001;
         default: mask = 3'b000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// h/v raster counters with registered request-stage coordinates, raw syncs and frame start.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter int unsigned XW       = coord_w(period(H_ACTIVE, H_FP, H_SYNC, H_BP)),
   parameter int unsigned YW       = coord_w(period(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
   input  logic          iVGA_CLK,
   input  logic          iRST_n,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          req,
   output logic          hs,
   output logic          vs,
   output logic          frame_start
);

   localparam int unsigned H_TOTAL  = period(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL  = period(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;

   logic [XW-1:0] h_q;
   logic [YW-1:0] v_q;

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         h_q         <= '0;
         v_q         <= '0;
         x           <= '0;
         y           <= '0;
         req         <= 1'b0;
         hs          <= 1'b0;
         vs          <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         x           <= h_q;
         y           <= v_q;
         req         <= (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
         hs          <= (32'(h_q) >= HS_START) && (32'(h_q) < HS_START + H_SYNC);
         vs          <= (32'(v_q) >= VS_START) && (32'(v_q) < VS_START + V_SYNC);
         frame_start <= (h_q == '0) && (v_q == '0);
         if (32'(h_q) == H_TOTAL - 1) begin
            h_q <= '0;
            v_q <= (32'(v_q) == V_TOTAL - 1) ? '0 : v_q + YW'(1);
         end else begin
            h_q <= h_q + XW'(1);
         end
      end
   end

endmodule

// File: rtl/vga_stream_controller.sv
// VGA controller: (x,y) requests, SRC_LAT-aligned colour return, HS/VS/BLANK aligned to colour.
// Define VGA_TEST_PATTERN_EN to add iTP_SEL and internal 8-bar colour pattern.
module vga_stream_controller
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned COLOR_W  = 4,
   parameter int unsigned SRC_LAT  = 2,
   localparam int unsigned XW      = coord_w(period(H_ACTIVE, H_FP, H_SYNC, H_BP)),
   localparam int unsigned YW      = coord_w(period(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
   input  logic                 iVGA_CLK,
   input  logic                 iRST_n,
   output logic [XW-1:0]        oX,
   output logic [YW-1:0]        oY,
   output logic                 oPIX_REQ,
`ifdef VGA_TEST_PATTERN_EN
   input  logic                 iTP_SEL,
`endif
   input  logic [3*COLOR_W-1:0] iPIX_RGB,
   output logic [COLOR_W-1:0]   oVGA_R,
   output logic [COLOR_W-1:0]   oVGA_G,
   output logic [COLOR_W-1:0]   oVGA_B,
   output logic                 oHS,
   output logic                 oVS,
   output logic                 oBLANK_n,
   output logic                 oFRAME_START
);

   logic  hs_raw, vs_raw;
   pipe_t req_stage, out_stage;

   vga_sync_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .XW       (XW),
      .YW       (YW)
   ) u_sync_gen (
      .iVGA_CLK    (iVGA_CLK),
      .iRST_n      (iRST_n),
      .x           (oX),
      .y           (oY),
      .req         (oPIX_REQ),
      .hs          (hs_raw),
      .vs          (vs_raw),
      .frame_start (oFRAME_START)
   );

`ifdef VGA_TEST_PATTERN_EN
   localparam int unsigned BAR_W = H_ACTIVE / 8;
`endif

   always_comb begin
      req_stage     = '0;
      req_stage.vis = oPIX_REQ;
      req_stage.hs  = hs_raw;
      req_stage.vs  = vs_raw;
`ifdef VGA_TEST_PATTERN_EN
      req_stage.tp  = iTP_SEL;
      // Bar 7 has no upper bound, so it absorbs the H_ACTIVE % 8 remainder.
      for (int i = 1; i < 8; i++) begin
         if (32'(oX) >= 32'(i) * BAR_W) req_stage.bar = 3'(i);
      end
`endif
   end

   if (SRC_LAT == 0) begin : g_no_delay
      assign out_stage = req_stage;
   end else begin : g_delay
      pipe_t dly_q [SRC_LAT];

      always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
         if (!iRST_n) begin
            for (int i = 0; i < int'(SRC_LAT); i++) dly_q[i] <= '0;
         end else begin
            dly_q[0] <= req_stage;
            for (int i = 1; i < int'(SRC_LAT); i++) dly_q[i] <= dly_q[i-1];
         end
      end

      assign out_stage = dly_q[SRC_LAT-1];
   end

   logic [2:0]           mask;
   logic [3*COLOR_W-1:0] rgb_d;

   always_comb begin
      mask  = bar_mask(out_stage.bar);
      rgb_d = '0;
      if (out_stage.vis) begin
         if (out_stage.tp) begin
            rgb_d = {{COLOR_W{mask[2]}}, {COLOR_W{mask[1]}}, {COLOR_W{mask[0]}}};
         end else begin
            rgb_d = iPIX_RGB;
         end
      end
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         oVGA_R   <= '0;
         oVGA_G   <= '0;
         oVGA_B   <= '0;
         oHS      <= ~HS_POL;
         oVS      <= ~VS_POL;
         oBLANK_n <= 1'b0;
      end else begin
         {oVGA_R, oVGA_G, oVGA_B} <= rgb_d;
         oHS      <= out_stage.hs ? HS_POL : ~HS_POL;
         oVS      <= out_stage.vs ? VS_POL : ~VS_POL;
         oBLANK_n <= out_stage.vis;
      end
   end

endmodule

// File: doc/vga_stream_controller.md
Name: vga_stream_controller

Overview:
Parametrised VGA controller. Generates sync timing and per-pixel (x,y) coordinates, requests colour from an external pixel source (e.g. the Tetris board renderer or a framebuffer) with a fixed, parameterised read latency, and aligns HS/VS/BLANK with the returned colour. It replaces linear-address colour generation with explicit 2-D coordinates, configurable timing, colour width and source latency.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, HS asserted level (0 = active-low)
VS_POL, 0, VS asserted level (0 = active-low)
COLOR_W, 4, bits per colour channel
SRC_LAT, 2, pixel-source latency in clocks (0..8)

Ports:
iVGA_CLK  in  1  pixel clock
iRST_n  in  1  asynchronous active-low reset
oX  out  XW=$clog2(H_TOTAL)  current pixel column (request stage)
oY  out  YW=$clog2(V_TOTAL)  current line (request stage)
oPIX_REQ  out  1  high when (oX,oY) is visible
iPIX_RGB  in  3*COLOR_W  {R,G,B} returned SRC_LAT clocks after request
oVGA_R / oVGA_G / oVGA_B  out  COLOR_W each  output colour
oHS / oVS  out  1  sync outputs, polarity per HS_POL/VS_POL
oBLANK_n  out  1  high during visible output pixels
oFRAME_START  out  1  one-clock pulse at request of (0,0)

Behaviour:
- Reset: iRST_n asynchronous, active-low; clock iVGA_CLK. During reset: h/v counters 0, oPIX_REQ 0, oFRAME_START 0, oHS=~HS_POL, oVS=~VS_POL, oBLANK_n 0, all colour outputs 0, delay-line contents cleared to inactive/blank.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line order: active, front porch, sync, back porch. Same for frames.
- h counts 0..H_TOTAL-1, then wraps to 0 and v increments. v wraps to 0 when h wraps at v=V_TOTAL-1. Simultaneous wrap gives frame start.
- oX/oY registered copies of h/v. oPIX_REQ = (h<H_ACTIVE)&&(v<V_ACTIVE). oFRAME_START = (h==0)&&(v==0).
- Raw HS asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). Raw VS asserted for v in the matching range over whole lines, switching at h wrap.
- Alignment: raw HS/VS/visible pass through an SRC_LAT-deep shift register. Output stage registers once more, so total latency from request to pins is SRC_LAT+1 clocks for all signals.
- Colour out = iPIX_RGB when delayed visible is 1, else 0. The source value is ignored during blanking.
- SRC_LAT=0: no delay line; output register only.
- After reset release, first request is (0,0) on the first clock edge. Reset mid-frame restarts at (0,0) with no partial-line artefacts.
- Counters never exceed H_TOTAL-1/V_TOTAL-1.

Optional Feature:
VGA_TEST_PATTERN_EN
- Defined: adds input iTP_SEL (1 bit). When iTP_SEL=1, iPIX_RGB is ignored and 8 vertical colour bars are generated internally: white, yellow, cyan, green, magenta, red, blue, black. Each bar is H_ACTIVE/8 wide; the last bar absorbs any remainder. Bars have the same SRC_LAT+1 latency. iTP_SEL is sampled at the request stage.
- Undefined: port absent; colour path is iPIX_RGB only.

Decomposition:
- Package vga_pkg: default timing constants, total-period functions, colour-bar RGB constants, coordinate width function.
- Sub-module vga_sync_gen: h/v counters, raw HS/VS/visible, frame-start. The top level holds the delay line, colour mux and output registers.

Test Plan:
1. Reset for 5 clocks -> oHS=1, oVS=1, oBLANK_n=0, RGB=0. First clock after release: oPIX_REQ=1, oX=0, oY=0, oFRAME_START=1.
2. Defaults, SRC_LAT=2 -> oHS low for exactly 96 clocks per line, period 800. oHS falls 656+3 clocks after h=0 request.
3. Full frame -> oVS low for 1600 clocks starting at line 490. oFRAME_START period 420000 clocks.
4. Source returns {x[3:0],y[3:0],x[7:4]} after 2 clocks, and drives FFF during blanking -> pixel (5,7) emerges 3 clocks later as R=5,G=7,B=0. All blanking pixels are 000.
5. Assert iRST_n low asynchronously at (300,200) -> outputs take reset values without a clock edge. Restart at (0,0).
6. VGA_TEST_PATTERN_EN, iTP_SEL=1 -> x=0..79 FFF, x=80..159 FF0, x=560..639 000, all with SRC_LAT+1 latency.
